// File: rtl/layer_sequencer.sv
// Layer sequencer for a neural-network datapath: issues one neuron at a time, stores results
// in ping-pong banks for feedback to the next layer, then streams out the final layer.
module layer_sequencer #(
  parameter int DWIDTH     = 32,
  parameter int MAX_OUT    = 16,
  parameter int MAX_LAYERS = 4,
  parameter int RELU       = 1,
  localparam int NW  = $clog2(MAX_OUT + 1),
  localparam int IW  = $clog2(MAX_OUT),
  localparam int LW  = $clog2(MAX_LAYERS + 1),
  localparam int LIW = $clog2(MAX_LAYERS)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [NW-1:0]     cfg_neurons,
  input  logic [LW-1:0]     cfg_layers,
  output logic              neuron_start,
  output logic [IW-1:0]     neuron_idx,
  output logic [LIW-1:0]    layer_idx,
  input  logic              neuron_done,
  input  logic [DWIDTH-1:0] neuron_out,
  input  logic [IW-1:0]     fb_addr,
  output logic [DWIDTH-1:0] fb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              layer_done,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FIN} state_t;

  state_t                   state;
  logic [NW-1:0]            n_cfg;
  logic [LW-1:0]            l_cfg;
  logic [IW-1:0]            drain_idx;
  logic signed [DWIDTH-1:0] bank [2][MAX_OUT];

  logic cfg_ok;
  logic last_neuron;
  logic last_layer;
  logic last_beat;
  logic bank_wr;
  logic fb_in_range;

  function automatic logic signed [DWIDTH-1:0] relu_fn(input logic signed [DWIDTH-1:0] x,
                                                       input logic apply);
    if (apply && x[DWIDTH-1]) return '0;
    return x;
  endfunction

  // Comparisons are widened by one bit so the range checks never become constant.
  assign cfg_ok = (cfg_neurons != '0) && ({1'b0, cfg_neurons} <= (NW+1)'(MAX_OUT)) &&
                  (cfg_layers != '0)  && ({1'b0, cfg_layers}  <= (LW+1)'(MAX_LAYERS));

  assign last_neuron = (NW'(neuron_idx) == n_cfg - NW'(1));
  assign last_layer  = (LW'(layer_idx)  == l_cfg - LW'(1));
  assign last_beat   = (NW'(drain_idx)  == n_cfg - NW'(1));
  assign bank_wr     = (state == WAIT) && neuron_done;
  assign fb_in_range = ({1'b0, fb_addr} < (IW+1)'(MAX_OUT));

  // The bank being written is selected by layer parity; feedback reads the other one.
  assign fb_data  = fb_in_range ? bank[~layer_idx[0]][fb_addr] : '0;
  assign out_data = bank[layer_idx[0]][drain_idx];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < MAX_OUT; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else if (bank_wr) begin
      bank[layer_idx[0]][neuron_idx] <= relu_fn(neuron_out, (RELU != 0) && !last_layer);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      n_cfg        <= '0;
      l_cfg        <= '0;
      neuron_idx   <= '0;
      layer_idx    <= '0;
      drain_idx    <= '0;
      neuron_start <= 1'b0;
      layer_done   <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      neuron_start <= 1'b0;
      layer_done   <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              n_cfg        <= cfg_neurons;
              l_cfg        <= cfg_layers;
              neuron_idx   <= '0;
              layer_idx    <= '0;
              drain_idx    <= '0;
              neuron_start <= 1'b1;
              state        <= ISSUE;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (neuron_done) begin
            if (!last_neuron) begin
              neuron_idx   <= neuron_idx + IW'(1);
              neuron_start <= 1'b1;
              state        <= ISSUE;
            end else begin
              neuron_idx <= '0;
              layer_done <= 1'b1;
              if (!last_layer) begin
                layer_idx    <= layer_idx + LIW'(1);
                neuron_start <= 1'b1;
                state        <= ISSUE;
              end else begin
                drain_idx <= '0;
                out_valid <= 1'b1;
                state     <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_beat) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              drain_idx <= drain_idx + IW'(1);
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two instances (ReLU on/off) driven together and compared every
// cycle against a transaction-count model, plus directed scenarios with literal expectations.
module tb_layer_sequencer;
  localparam int DW  = 16;
  localparam int MO  = 6;
  localparam int ML  = 4;
  localparam int NW  = $clog2(MO + 1);
  localparam int IW  = $clog2(MO);
  localparam int LW  = $clog2(ML + 1);
  localparam int LIW = $clog2(ML);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] cfg_neurons = '0;
  logic [LW-1:0] cfg_layers = '0;
  logic          neuron_done = 1'b0;
  logic [DW-1:0] neuron_out = '0;
  logic [IW-1:0] fb_addr = '0;
  logic          out_ready = 1'b0;

  logic a_ns, a_ov, a_ld, a_busy, a_done, a_err;
  logic b_ns, b_ov, b_ld, b_busy, b_done, b_err;
  logic [IW-1:0] a_ni, b_ni;
  logic [LIW-1:0] a_li, b_li;
  logic [DW-1:0] a_fb, b_fb, a_od, b_od;

  layer_sequencer #(.DWIDTH(DW), .MAX_OUT(MO), .MAX_LAYERS(ML), .RELU(1)) dut_a (
    .clk(clk), .nreset(nreset), .start(start), .cfg_neurons(cfg_neurons), .cfg_layers(cfg_layers),
    .neuron_start(a_ns), .neuron_idx(a_ni), .layer_idx(a_li), .neuron_done(neuron_done),
    .neuron_out(neuron_out), .fb_addr(fb_addr), .fb_data(a_fb), .out_valid(a_ov),
    .out_ready(out_ready), .out_data(a_od), .layer_done(a_ld), .busy(a_busy), .done(a_done),
    .cfg_err(a_err));

  layer_sequencer #(.DWIDTH(DW), .MAX_OUT(MO), .MAX_LAYERS(ML), .RELU(0)) dut_b (
    .clk(clk), .nreset(nreset), .start(start), .cfg_neurons(cfg_neurons), .cfg_layers(cfg_layers),
    .neuron_start(b_ns), .neuron_idx(b_ni), .layer_idx(b_li), .neuron_done(neuron_done),
    .neuron_out(neuron_out), .fb_addr(fb_addr), .fb_data(b_fb), .out_valid(b_ov),
    .out_ready(out_ready), .out_data(b_od), .layer_done(b_ld), .busy(b_busy), .done(b_done),
    .cfg_err(b_err));

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a run is N*L neuron completions followed by N output beats.
  bit     m_active = 0, m_issue = 0, m_fin = 0, m_ldone = 0, m_err = 0;
  int     m_n = 1, m_l = 1, m_cnt = 0, m_beats = 0;
  longint hist [ML][MO];

  initial forever begin
    @(posedge clk or negedge nreset);
    if (!nreset) begin
      m_active = 0; m_issue = 0; m_fin = 0; m_ldone = 0; m_err = 0;
      m_n = 1; m_l = 1; m_cnt = 0; m_beats = 0;
    end else begin
      m_ldone = 0;
      m_err = 0;
      if (!m_active) begin
        if (start) begin
          if (cfg_neurons >= 1 && int'(cfg_neurons) <= MO && cfg_layers >= 1 && int'(cfg_layers) <= ML) begin
            m_active = 1; m_issue = 1;
            m_n = int'(cfg_neurons); m_l = int'(cfg_layers);
            m_cnt = 0; m_beats = 0;
          end else begin
            m_err = 1;
          end
        end
      end else if (m_fin) begin
        m_active = 0; m_fin = 0;
      end else if (m_issue) begin
        m_issue = 0;
      end else if (m_cnt < m_n * m_l) begin
        if (neuron_done) begin
          hist[m_cnt / m_n][m_cnt % m_n] = longint'($signed(neuron_out));
          m_cnt++;
          if (m_cnt % m_n == 0) m_ldone = 1;
          if (m_cnt < m_n * m_l) m_issue = 1;
        end
      end else if (out_ready) begin
        m_beats++;
        if (m_beats == m_n) m_fin = 1;
      end
    end
  end

  function automatic longint exp_val(input int lay, input int idx, input bit r);
    longint v = hist[lay][idx];
    if (r && lay != m_l - 1 && v < 0) v = 0;
    return v;
  endfunction

  task automatic cmp_dut(input string t, input bit r, input logic ns, input logic [IW-1:0] ni,
                         input logic [LIW-1:0] li, input logic [DW-1:0] fb, input logic ov,
                         input logic [DW-1:0] od, input logic ld, input logic by,
                         input logic dn, input logic ce);
    int lay;
    bit ov_e;
    lay  = m_cnt / m_n;
    if (lay > m_l - 1) lay = m_l - 1;
    ov_e = m_active && (m_cnt == m_n * m_l) && !m_fin;
    chk({t, ".neuron_start"}, ns, m_issue);
    chk({t, ".neuron_idx"}, ni, m_cnt % m_n);
    chk({t, ".layer_idx"}, li, lay);
    chk({t, ".out_valid"}, ov, ov_e);
    chk({t, ".layer_done"}, ld, m_ldone);
    chk({t, ".busy"}, by, m_active);
    chk({t, ".done"}, dn, m_fin);
    chk({t, ".cfg_err"}, ce, m_err);
    if (ov_e) chk({t, ".out_data"}, $signed(od), exp_val(m_l - 1, m_beats, r));
    if (m_active && m_cnt < m_n * m_l && lay >= 1 && int'(fb_addr) < m_n)
      chk({t, ".fb_data"}, $signed(fb), exp_val(lay - 1, int'(fb_addr), r));
  endtask

  initial forever begin
    @(negedge clk);
    cmp_dut("a", 1'b1, a_ns, a_ni, a_li, a_fb, a_ov, a_od, a_ld, a_busy, a_done, a_err);
    cmp_dut("b", 1'b0, b_ns, b_ni, b_li, b_fb, b_ov, b_od, b_ld, b_busy, b_done, b_err);
  end

  // Pulse counters and captured output streams.
  int ld_a = 0, dn_a = 0, ns_a = 0;
  logic signed [DW-1:0] q_a[$], q_b[$];

  initial forever begin
    @(negedge clk);
    if (a_ld) ld_a++;
    if (a_done) dn_a++;
    if (a_ns) ns_a++;
    if (a_ov && out_ready) q_a.push_back($signed(a_od));
    if (b_ov && out_ready) q_b.push_back($signed(b_od));
  end

  bit fb_manual = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!fb_manual) fb_addr = IW'($urandom_range(0, (1 << IW) - 1));
  end

  int stim [ML][MO];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_ns) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("issue_seen", a_ns, 1);
  endtask

  task automatic run_seq(input int n, input int l, input bit spur, input int mode,
                         input int abort_at, input bit lit);
    bit ok;
    int beat, stall;
    bit rdy;
    int lit_a[3] = '{5, 0, 7};
    int lit_b[3] = '{5, -2, 7};
    q_a.delete();
    q_b.delete();
    cfg_neurons = NW'(n);
    cfg_layers  = LW'(l);
    start = 1;
    if (spur) begin
      neuron_done = 1;
      neuron_out  = DW'(16'sh7FFF);
    end
    tick();
    start = 0;
    cfg_neurons = NW'($urandom_range(0, MO));
    for (int k = 0; k < n * l; k++) begin
      wait_issue(ok);
      if (!ok) return;
      tick();
      neuron_done = 0;
      if (k == abort_at) begin
        nreset = 0;
        @(negedge clk);
        chk("rst.busy", a_busy, 0);
        chk("rst.neuron_start", a_ns, 0);
        chk("rst.neuron_idx", a_ni, 0);
        chk("rst.layer_idx", a_li, 0);
        chk("rst.out_valid", a_ov, 0);
        chk("rst.out_data", a_od, 0);
        chk("rst.fb_data", a_fb, 0);
        chk("rst.layer_done", a_ld, 0);
        chk("rst.done", a_done, 0);
        chk("rst.cfg_err", a_err, 0);
        tick();
        tick();
        nreset = 1;
        tick();
        return;
      end
      if (lit && k == n) begin
        fb_manual = 1;
        start = 1;
        cfg_neurons = NW'(1);
        cfg_layers  = LW'(1);
        for (int a = 0; a < 3; a++) begin
          fb_addr = IW'(a);
          @(negedge clk);
          chk("lit.fb_relu", $signed(a_fb), lit_a[a]);
          chk("lit.fb_raw", $signed(b_fb), lit_b[a]);
          tick();
        end
        start = 0;
        fb_manual = 0;
      end
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 2) == 0) begin
          start = 1;
          cfg_neurons = NW'($urandom_range(1, MO));
          cfg_layers  = LW'($urandom_range(1, ML));
        end
        tick();
        start = 0;
      end
      neuron_done = 1;
      neuron_out  = DW'(stim[k / n][k % n]);
      tick();
      neuron_done = spur;
    end
    beat = 0;
    stall = 0;
    for (int c = 0; c < 100 && beat < n; c++) begin
      if (mode == 1) rdy = !(beat == 1 && stall < 3);
      else rdy = ($urandom_range(0, 3) != 0);
      out_ready = rdy;
      @(negedge clk);
      if (mode == 1 && beat == 1 && !rdy) begin
        chk("stall.out_data", $signed(a_od), stim[l - 1][1]);
        chk("stall.out_valid", a_ov, 1);
        stall++;
      end
      if (a_ov && rdy) beat++;
      tick();
      neuron_done = 0;
    end
    out_ready = 0;
    chk("drain.beats", beat, n);
    @(negedge clk);
    chk("fin.done", a_done, 1);
    tick();
  endtask

  task automatic check_stream(input int n, input int l);
    chk("stream_a.len", q_a.size(), n);
    chk("stream_b.len", q_b.size(), n);
    for (int i = 0; i < n && i < q_a.size(); i++) chk("stream_a.data", q_a[i], stim[l - 1][i]);
    for (int i = 0; i < n && i < q_b.size(); i++) chk("stream_b.data", q_b[i], stim[l - 1][i]);
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 9))
      0: return -32768;
      1: return 32767;
      default: return int'($urandom_range(0, 400)) - 200;
    endcase
  endfunction

  initial begin
    int ld0, dn0, ns0, n, l;
    int exp31[3] = '{-1, 4, 9};
    int exp32[3] = '{10, 20, 30};
    repeat (3) tick();
    chk("reset.busy", a_busy, 0);
    chk("reset.out_valid", a_ov, 0);
    chk("reset.fb_data", a_fb, 0);
    nreset = 1;
    tick();

    // Rejected configurations.
    cfg_neurons = '0; cfg_layers = LW'(2); start = 1;
    tick(); start = 0;
    @(negedge clk);
    chk("err_n0.cfg_err", a_err, 1);
    chk("err_n0.busy", a_busy, 0);
    tick();
    @(negedge clk);
    chk("err_n0.clear", a_err, 0);
    tick();
    cfg_neurons = NW'(2); cfg_layers = LW'(ML + 1); start = 1;
    tick(); start = 0;
    @(negedge clk);
    chk("err_l.cfg_err", a_err, 1);
    chk("err_l.busy", a_busy, 0);
    tick();

    // Spurious neuron_done while idle.
    neuron_done = 1; tick(); tick(); neuron_done = 0;
    @(negedge clk);
    chk("idle_done.busy", a_busy, 0);
    tick();

    // N=3, L=2 with ReLU feedback.
    stim[0][0] = 5;  stim[0][1] = -2; stim[0][2] = 7;
    stim[1][0] = -1; stim[1][1] = 4;  stim[1][2] = 9;
    ld0 = ld_a; dn0 = dn_a;
    run_seq(3, 2, 1'b1, 0, -1, 1'b1);
    chk("r31.len", q_a.size(), 3);
    for (int i = 0; i < 3 && i < q_a.size(); i++) chk("r31.stream", q_a[i], exp31[i]);
    chk("r31.layer_done", ld_a - ld0, 2);
    chk("r31.done", dn_a - dn0, 1);

    // Backpressure on beat 1.
    stim[0][0] = 10; stim[0][1] = 20; stim[0][2] = 30;
    run_seq(3, 1, 1'b0, 1, -1, 1'b0);
    chk("r32.len", q_a.size(), 3);
    for (int i = 0; i < 3 && i < q_a.size(); i++) chk("r32.stream", q_a[i], exp32[i]);

    // Reset in the middle of layer 1, then a full-size run.
    for (int a = 0; a < ML; a++) for (int b = 0; b < MO; b++) stim[a][b] = rand_val();
    ld0 = ld_a; dn0 = dn_a;
    run_seq(3, 2, 1'b0, 0, 4, 1'b0);
    chk("abort.done", dn_a - dn0, 0);
    chk("abort.layer_done", ld_a - ld0, 1);
    ld0 = ld_a; dn0 = dn_a;
    run_seq(MO, ML, 1'b0, 0, -1, 1'b0);
    check_stream(MO, ML);
    chk("full.layer_done", ld_a - ld0, ML);
    chk("full.done", dn_a - dn0, 1);

    // Single neuron, single layer.
    stim[0][0] = -3;
    ns0 = ns_a; dn0 = dn_a;
    run_seq(1, 1, 1'b0, 0, -1, 1'b0);
    chk("r36.neuron_start", ns_a - ns0, 1);
    chk("r36.len", q_b.size(), 1);
    if (q_b.size() > 0) chk("r36.stream", q_b[0], -3);
    chk("r36.done", dn_a - dn0, 1);

    // Randomized runs.
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, MO);
      l = $urandom_range(1, ML);
      for (int a = 0; a < ML; a++) for (int b = 0; b < MO; b++) stim[a][b] = rand_val();
      ld0 = ld_a; dn0 = dn_a; ns0 = ns_a;
      run_seq(n, l, 1'($urandom_range(0, 1)), 0, -1, 1'b0);
      check_stream(n, l);
      chk("rand.layer_done", ld_a - ld0, l);
      chk("rand.done", dn_a - dn0, 1);
      chk("rand.neuron_start", ns_a - ns0, n * l);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning the signed two's-complement fixed-point neuron output width.
REQ-002 The block SHALL have parameter MAX_OUT, default 16, meaning the maximum neurons per layer (>=2).
REQ-003 The block SHALL have parameter MAX_LAYERS, default 4, meaning the maximum layers per run (>=2).
REQ-004 The block SHALL have parameter RELU, default 1, meaning ReLU is applied to non-final layer outputs when 1 and bypassed when 0.
REQ-005 The block SHALL use derived widths NW=$clog2(MAX_OUT+1), IW=$clog2(MAX_OUT), LW=$clog2(MAX_LAYERS+1) and LIW=$clog2(MAX_LAYERS).
REQ-006 The block SHALL have the following ports (reset nreset, asynchronous, active-low; clock clk):
 clk  in  1  clock
 nreset  in  1  asynchronous active-low reset
 start  in  1  run request, sampled in IDLE only
 cfg_neurons  in  NW  neurons per layer
 cfg_layers  in  LW  layer count
 neuron_start  out  1  one-cycle pulse to the neuron datapath
 neuron_idx  out  IW  current neuron index
 layer_idx  out  LIW  current layer index
 neuron_done  in  1  datapath completion pulse
 neuron_out  in  DWIDTH  datapath result, valid with neuron_done
 fb_addr  in  IW  previous-layer read address
 fb_data  out  DWIDTH  previous-layer value, combinational read
 out_valid  out  1  final-result stream valid
 out_ready  in  1  final-result stream ready
 out_data  out  DWIDTH  final-result data
 layer_done  out  1  one-cycle pulse per completed layer
 busy  out  1  high whenever state != IDLE
 done  out  1  one-cycle pulse at run end
 cfg_err  out  1  one-cycle pulse on rejected start

Function
REQ-007 The block SHALL implement FSM states IDLE, ISSUE, WAIT, DRAIN and FIN.
REQ-008 In IDLE, start=1 with 1<=cfg_neurons<=MAX_OUT and 1<=cfg_layers<=MAX_LAYERS SHALL latch the configuration, clear neuron_idx and layer_idx, and go to ISSUE.
REQ-009 In IDLE, start=1 with an out-of-range configuration SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-010 In any state other than IDLE, start and configuration changes SHALL be ignored.
REQ-011 In ISSUE, neuron_start SHALL be 1 for exactly one cycle, after which the FSM goes to WAIT.
REQ-012 neuron_done SHALL be ignored in every state except WAIT.
REQ-013 In WAIT, neuron_done SHALL write the stored value into bank[layer_idx[0]][neuron_idx].
REQ-014 The stored value SHALL be 0 if RELU=1, the current layer is not the last, and neuron_out[DWIDTH-1]=1; otherwise it SHALL be neuron_out unchanged.
REQ-015 On neuron_done in WAIT with neuron_idx<N-1, neuron_idx SHALL increment and the FSM SHALL go to ISSUE.
REQ-016 On neuron_done in WAIT with neuron_idx=N-1, layer_done SHALL pulse on the next cycle and neuron_idx SHALL clear.
REQ-017 In the case of REQ-016, if layer_idx<L-1 then layer_idx SHALL increment and the FSM SHALL go to ISSUE; otherwise it SHALL go to DRAIN.
REQ-018 fb_data SHALL equal bank[~layer_idx[0]][fb_addr], i.e. the ping-pong bank not being written.
REQ-019 fb_data content SHALL be don't-care during layer 0.
REQ-020 fb_addr values >= N SHALL return a don't-care value without corrupting state.
REQ-021 In DRAIN, the block SHALL present entries 0..N-1 of the final bank in order on out_data with out_valid=1.
REQ-022 In DRAIN, the index SHALL advance only on out_valid&out_ready.
REQ-023 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 After the handshake on entry N-1, out_valid SHALL drop and the FSM SHALL go to FIN.
REQ-025 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-026 Minimum latency from start to the first neuron_start SHALL be 1 cycle.
REQ-027 A neuron_done arriving in the same cycle as neuron_start SHALL be ignored.
REQ-028 N=1 and L=1 SHALL both be legal; N=1 SHALL give one neuron_start per layer and a single-beat drain.

Reset
REQ-029 Asserting nreset SHALL force state IDLE, clear all counters, drive every output to 0 and clear both banks to 0, at any time including mid-run or mid-drain.
REQ-030 No done or layer_done pulse SHALL be emitted for a run aborted by reset.

Verification
REQ-031 The bench SHALL cover: N=3, L=2, RELU=1, outputs L0={5,-2,7}, L1={-1,4,9} -> fb_data during L1 = {5,0,7}; stream {-1,4,9}; layer_done x2; done x1.
REQ-032 The bench SHALL cover: out_ready low 3 cycles on beat 1 -> out_data frozen at beat-1 value, with no skipped or duplicated beats.
REQ-033 The bench SHALL cover: start with cfg_neurons=0, and separately cfg_layers=MAX_LAYERS+1 -> cfg_err pulse, busy stays 0.
REQ-034 The bench SHALL cover: spurious neuron_done in ISSUE and in IDLE, and start during WAIT -> no state or count change.
REQ-035 The bench SHALL cover: nreset asserted mid-WAIT of layer 1 -> all outputs 0 immediately; a subsequent run N=MAX_OUT, L=MAX_LAYERS completes correctly.
REQ-036 The bench SHALL cover: N=1, L=1, RELU=0, neuron_out=-3 -> one neuron_start, stream {-3}, done.
